// File: rtl/sys_bus.sv
// Two-requester memory/IO fabric: ROM-only fetch port and a data port onto inputs,
// latched outputs and RAM, shared through one req/ack bus with programmable wait states.
module sys_bus #(
  parameter int ROM_ADDR_WIDTH = 4,
  parameter int INSTR_WIDTH    = 16,
  parameter int RAM_ADDR_WIDTH = 3,
  parameter int N_IN           = 2,
  parameter int N_OUT          = 2,
  parameter int WAIT_STATES    = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [(2**ROM_ADDR_WIDTH)*INSTR_WIDTH-1:0]  mem,
  input  logic [N_IN*8-1:0]                           inputs,
  output logic [N_OUT*8-1:0]                          outputs,
  input  logic                                        fetch_req,
  input  logic [7:0]                                  fetch_addr,
  output logic                                        fetch_ack,
  output logic [INSTR_WIDTH-1:0]                      fetch_data,
  input  logic                                        data_req,
  input  logic                                        data_we,
  input  logic [7:0]                                  data_addr,
  input  logic [7:0]                                  data_wdata,
  output logic                                        data_ack,
  output logic [7:0]                                  data_rdata,
  output logic                                        bus_err
);

  localparam int ROM_DEPTH = 2**ROM_ADDR_WIDTH;
  localparam int RAM_DEPTH = 2**RAM_ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     gnt_data_q, gnt_data_d;
  logic [7:0]               addr_q, addr_d;
  logic                     we_q, we_d;
  logic [7:0]               wdata_q, wdata_d;
  logic                     fetch_ack_q, fetch_ack_d;
  logic                     data_ack_q, data_ack_d;
  logic                     bus_err_q, bus_err_d;
  logic [INSTR_WIDTH-1:0]   fetch_data_q, fetch_data_d;
  logic [7:0]               data_rdata_q, data_rdata_d;
  logic [7:0]               out_q [N_OUT];
  logic [7:0]               out_d [N_OUT];
  logic [7:0]               ram_q [RAM_DEPTH];
  logic [7:0]               ram_d [RAM_DEPTH];

  logic [INSTR_WIDTH-1:0]   rom_w [ROM_DEPTH];
  logic [7:0]               in_w  [N_IN];

  logic                     cur_data;
  logic [7:0]               cur_addr;
  logic                     cur_we;
  logic [7:0]               d_rd;
  logic                     d_err;
  logic [INSTR_WIDTH-1:0]   f_rd;
  logic                     f_err;
  logic                     enter_ack;

  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    assign rom_w[k] = mem[k*INSTR_WIDTH +: INSTR_WIDTH];
  end
  for (genvar k = 0; k < N_IN; k++) begin : g_in
    assign in_w[k] = inputs[k*8 +: 8];
  end
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign outputs[k*8 +: 8] = out_q[k];
  end

  assign fetch_ack  = fetch_ack_q;
  assign fetch_data = fetch_data_q;
  assign data_ack   = data_ack_q;
  assign data_rdata = data_rdata_q;
  assign bus_err    = bus_err_q;

  // In IDLE the live request is decoded so a zero-wait grant can answer at the grant edge.
  always_comb begin
    cur_data = gnt_data_q;
    cur_addr = addr_q;
    cur_we   = we_q;
    if (state_q == S_IDLE) begin
      cur_data = data_req;
      cur_addr = data_req ? data_addr : fetch_addr;
      cur_we   = data_req & data_we;
    end
  end

  always_comb begin
    d_rd  = '0;
    d_err = 1'b1;
    case (cur_addr[7:6])
      2'd0: for (int k = 0; k < N_IN; k++)
              if (cur_addr[5:0] == 6'(k)) begin
                d_rd  = in_w[k];
                d_err = cur_we;
              end
      2'd1: for (int k = 0; k < N_OUT; k++)
              if (cur_addr[5:0] == 6'(k)) begin
                d_rd  = out_q[k];
                d_err = 1'b0;
              end
      2'd2: for (int k = 0; k < RAM_DEPTH; k++)
              if (cur_addr[5:0] == 6'(k)) begin
                d_rd  = ram_q[k];
                d_err = 1'b0;
              end
      default: ;
    endcase
  end

  always_comb begin
    f_err = ({1'b0, cur_addr} >= 9'(ROM_DEPTH));
    f_rd  = f_err ? '0 : rom_w[cur_addr[ROM_ADDR_WIDTH-1:0]];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_data_d   = gnt_data_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    fetch_ack_d  = 1'b0;
    data_ack_d   = 1'b0;
    bus_err_d    = 1'b0;
    fetch_data_d = fetch_data_q;
    data_rdata_d = data_rdata_q;
    out_d        = out_q;
    ram_d        = ram_q;
    enter_ack    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_req || fetch_req) begin
          gnt_data_d = data_req;
          addr_d     = cur_addr;
          we_d       = cur_we;
          wdata_d    = data_wdata;
          if (WAIT_STATES == 0) begin
            state_d   = S_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        // Writes land on the edge that closes the ack cycle, so the read-back sees the old value.
        if (gnt_data_q && we_q) begin
          case (addr_q[7:6])
            2'd1: for (int k = 0; k < N_OUT; k++)
                    if (addr_q[5:0] == 6'(k)) out_d[k] = wdata_q;
            2'd2: for (int k = 0; k < RAM_DEPTH; k++)
                    if (addr_q[5:0] == 6'(k)) ram_d[k] = wdata_q;
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_ack) begin
      if (cur_data) begin
        data_ack_d   = 1'b1;
        data_rdata_d = d_rd;
        bus_err_d    = d_err;
      end else begin
        fetch_ack_d  = 1'b1;
        fetch_data_d = f_rd;
        bus_err_d    = f_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gnt_data_q   <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      fetch_ack_q  <= 1'b0;
      data_ack_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      fetch_data_q <= '0;
      data_rdata_q <= '0;
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      for (int k = 0; k < RAM_DEPTH; k++) ram_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_data_q   <= gnt_data_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      fetch_ack_q  <= fetch_ack_d;
      data_ack_q   <= data_ack_d;
      bus_err_q    <= bus_err_d;
      fetch_data_q <= fetch_data_d;
      data_rdata_q <= data_rdata_d;
      out_q        <= out_d;
      ram_q        <= ram_d;
    end
  end

endmodule
